e_mdu: RTL

Execute-stage multiply/divide unit: the consumer of the `start_E`, `RS_E`, `RT_E` fields held in the D→E pipeline register. It runs multi-cycle mult/div operations and holds the HI/LO architectural registers. It exports `busy` so the hazard unit can stall decode. The unit sits beside the E-stage ALU; its HI/LO outputs feed the mfhi/mflo result mux.

---
 rtl/e_mdu.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit holding the HI/LO registers.
// Define MDU_MADD_EN to build the accumulate ops (madd/maddu/msub/msubu).
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state, state_next;
  logic [CW-1:0]  cnt, cnt_next;
  logic [31:0]    tmp_hi, tmp_lo;
  logic           tmp_wr;
  logic [31:0]    res_hi, res_lo;
  logic           res_wr;
  logic           is_mult, is_div, launch, commit;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;

  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Zero and INT_MIN/-1 divisors are swapped for 1 so the divider never
  // sees an undefined case; INT_MIN/1 already gives the required result.
  logic               div_zero, div_ovf;
  logic signed [31:0] dvs_s, quot_s, rem_s;
  logic [31:0]        dvs_u, quot_u, rem_u;

  assign div_zero = (B == 32'd0);
  assign div_ovf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
  assign dvs_s    = (div_zero || div_ovf) ? 32'sd1 : $signed(B);
  assign quot_s   = $signed(A) / dvs_s;
  assign rem_s    = $signed(A) % dvs_s;
  assign dvs_u    = div_zero ? 32'd1 : B;
  assign quot_u   = A / dvs_u;
  assign rem_u    = A % dvs_u;

`ifdef MDU_MADD_EN
  logic [63:0] acc_base;
  assign acc_base = {HI, LO};
`endif

  always_comb begin
    res_hi  = '0;
    res_lo  = '0;
    res_wr  = 1'b1;
    is_mult = 1'b0;
    is_div  = 1'b0;
    case (op)
      4'd0: begin is_mult = 1'b1; {res_hi, res_lo} = prod_s; end
      4'd1: begin is_mult = 1'b1; {res_hi, res_lo} = prod_u; end
      4'd2: begin
        is_div = 1'b1;
        res_wr = !div_zero;
        res_lo = quot_s;
        res_hi = rem_s;
      end
      4'd3: begin
        is_div = 1'b1;
        res_wr = !div_zero;
        res_lo = quot_u;
        res_hi = rem_u;
      end
`ifdef MDU_MADD_EN
      4'd6: begin is_mult = 1'b1; {res_hi, res_lo} = acc_base + $unsigned(prod_s); end
      4'd7: begin is_mult = 1'b1; {res_hi, res_lo} = acc_base + prod_u; end
      4'd8: begin is_mult = 1'b1; {res_hi, res_lo} = acc_base - $unsigned(prod_s); end
      4'd9: begin is_mult = 1'b1; {res_hi, res_lo} = acc_base - prod_u; end
`endif
      default: ;
    endcase
  end

  assign launch = start && (state == IDLE) && (is_mult || is_div);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    commit     = 1'b0;
    case (state)
      IDLE: if (launch) begin
        state_next = RUN;
        cnt_next   = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end
      RUN: if (cnt <= CW'(1)) begin
        state_next = IDLE;
        cnt_next   = '0;
        commit     = 1'b1;
      end else begin
        cnt_next = cnt - CW'(1);
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmp_hi <= '0;
      tmp_lo <= '0;
      tmp_wr <= 1'b0;
    end else if (launch) begin
      tmp_hi <= res_hi;
      tmp_lo <= res_lo;
      tmp_wr <= res_wr;
    end
  end

  // Completed ops commit from the temps; mthi/mtlo write directly, only when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      HI <= '0;
      LO <= '0;
    end else if (commit) begin
      if (tmp_wr) begin
        HI <= tmp_hi;
        LO <= tmp_lo;
      end
    end else if (start && (state == IDLE)) begin
      if (op == 4'd4) HI <= A;
      if (op == 4'd5) LO <= A;
    end
  end

  assign busy = (state == RUN);

endmodule
